regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised general-purpose register file for the 24-bit CPU datapath. Provides two combinational read ports and one synchronous write port.
- Optional hardwired zero register and optional write-to-read bypass.
- Dedicated double-width multiply result register (MULREG) with HI/LO read-out.
- Sequential bulk-clear engine, used by the control unit on soft reset or context flush.

Parameters:
- DATA_WIDTH, 24, width of each register in bits.
- ADDR_WIDTH, 4, register address width; DEPTH = 2**ADDR_WIDTH registers.
- BYPASS, 1, 1 = read port returns WriteData when the same-cycle write targets the read address.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- RS  input  ADDR_WIDTH  read port A address.
- RT  input  ADDR_WIDTH  read port B address.
- RD  input  ADDR_WIDTH  write address.
- WriteData  input  DATA_WIDTH  write data.
- RegWrite  input  1  write enable.
- ReadRS  output  DATA_WIDTH  read port A data.
- ReadRT  output  DATA_WIDTH  read port B data.
- MulWrite  input  1  load MULREG.
- MulData  input  2*DATA_WIDTH  product to load.
- MulHi  output  DATA_WIDTH  MULREG[2*DATA_WIDTH-1:DATA_WIDTH].
- MulLo  output  DATA_WIDTH  MULREG[DATA_WIDTH-1:0].
- ClearReq  input  1  start bulk clear (level sampled in IDLE).
- Busy  output  1  clear engine active.
- ClearDone  output  1  one-cycle pulse at clear completion.

Behaviour:
Reset:
- Reset high (asynchronous) immediately forces all DEPTH registers to 0 and MULREG to 0.
- FSM goes to IDLE; clear counter goes to 0; Busy=0; ClearDone=0.
- Reset asserted mid-clear aborts the clear. No ClearDone is produced.

Reads:
- Combinational, zero latency.
- If ZERO_REG and address==0: output 0.
- Else if BYPASS, RegWrite, !Busy, RD==address, and RD is not the hardwired zero register: output WriteData.
- Otherwise output the stored value.
- ReadRS and ReadRT are independent; both may bypass in the same cycle.

Write:
- On the rising edge with RegWrite=1 and Busy=0, Register[RD] <= WriteData.
- The write is dropped if ZERO_REG and RD==0.
- RegWrite while Busy=1 is silently dropped. The control unit must not issue writes while Busy is high.

MULREG:
- On the rising edge with MulWrite=1 and Busy=0, MULREG <= MulData.
- MulWrite while Busy=1 is dropped.
- MulHi and MulLo are combinational slices of MULREG. There is no bypass on the MUL path.

Clear FSM (states IDLE, CLEAR, DONE):
- IDLE:
  - ClearReq=1 at a rising edge moves to CLEAR and sets the counter to 0.
  - Any RegWrite or MulWrite at that same edge is still performed; it is erased later by the clear.
- CLEAR:
  - Busy=1.
  - Each edge writes Register[counter] <= 0 and increments the counter.
  - At counter==DEPTH-1, the same edge also clears MULREG and moves to DONE.
  - Duration is exactly DEPTH cycles. The counter does not wrap past DEPTH-1.
- DONE:
  - Busy=1, ClearDone=1 for exactly one cycle.
  - Next edge moves to IDLE; Busy=0.
- ClearReq is ignored outside IDLE. If ClearReq is still high on return to IDLE, a new clear starts at the next edge.
- Total Busy duration is DEPTH+1 cycles: 17 at defaults.
- Reads stay valid throughout the clear. Already-cleared registers read 0; the rest retain their values.

Width rules:
- No arithmetic on data; data is stored verbatim.
- The counter is ADDR_WIDTH+1 bits internally so the terminal compare is unambiguous.

Test Plan:
- Reset then reads:
  - Stimulus: assert Reset asynchronously mid-cycle; read RS=0..15.
  - Required: all reads 0, MulHi=MulLo=0, Busy=0 without waiting for a clock edge.
- Write/read with bypass (BYPASS=1):
  - Stimulus: RD=5, WriteData=24'hABCDEF, RegWrite=1, RS=5.
  - Required: ReadRS=24'hABCDEF in the same cycle, and again the next cycle with RegWrite=0.
  - With BYPASS=0: ReadRS shows the old value 0 in the write cycle.
- Zero register:
  - Stimulus: RD=0, WriteData=24'h123456, RegWrite=1; then RS=RT=0.
  - Required: ReadRS=ReadRT=0, including during the write cycle (no bypass).
- MULREG:
  - Stimulus: MulWrite=1, MulData=48'h000001_FFFFFE.
  - Required: next cycle MulHi=24'h000001, MulLo=24'hFFFFFE.
- Bulk clear:
  - Stimulus: preload r1..r15 with 24'h0000nn (nn = index) and MULREG with a nonzero value; pulse ClearReq one cycle.
  - Required: Busy high for exactly 17 cycles; r3 reads 0 from the cycle after its clear edge while r10 still reads 24'h00000A; ClearDone pulses once at the last Busy cycle; afterwards all registers and MULREG read 0.
  - RegWrite to RD=7 issued mid-clear is dropped; r7 stays 0.
- Reset mid-clear:
  - Stimulus: assert Reset at counter==8.
  - Required: immediate Busy=0 and all registers 0; no ClearDone; a fresh ClearReq afterwards completes normally in 17 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Register file: 2 comb read ports, 1 sync write port, MULREG, bulk-clear engine.
// Latency: reads 0 cycles (optional write bypass); writes/MULREG land at the next rising edge.
// Backpressure: Busy is high for DEPTH+1 cycles during a clear; RegWrite/MulWrite are dropped then.
module regfile_param #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 4,
   parameter bit BYPASS     = 1'b1,
   parameter bit ZERO_REG   = 1'b1
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [ADDR_WIDTH-1:0]   RS,
   input  logic [ADDR_WIDTH-1:0]   RT,
   input  logic [ADDR_WIDTH-1:0]   RD,
   input  logic [DATA_WIDTH-1:0]   WriteData,
   input  logic                    RegWrite,
   output logic [DATA_WIDTH-1:0]   ReadRS,
   output logic [DATA_WIDTH-1:0]   ReadRT,
   input  logic                    MulWrite,
   input  logic [2*DATA_WIDTH-1:0] MulData,
   output logic [DATA_WIDTH-1:0]   MulHi,
   output logic [DATA_WIDTH-1:0]   MulLo,
   input  logic                    ClearReq,
   output logic                    Busy,
   output logic                    ClearDone
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   // One extra counter bit keeps the terminal compare free of wrap ambiguity.
   localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH:0]     cnt;
   logic [DATA_WIDTH-1:0]   regs [DEPTH];
   logic [2*DATA_WIDTH-1:0] mulreg;

   logic wr_en;
   logic mul_en;
   logic clr_en;
   logic clr_last;

   // Writes are suppressed while the clear engine owns the array; register 0 may be hardwired.
   assign wr_en    = RegWrite && !Busy && !(ZERO_REG && (RD == '0));
   assign mul_en   = MulWrite && !Busy;
   assign clr_en   = (state == CLEAR);
   assign clr_last = clr_en && (cnt == CNT_LAST);

   // Clear sequencer: IDLE -> CLEAR (DEPTH edges) -> DONE (one cycle) -> IDLE.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         Busy      <= 1'b0;
         ClearDone <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ClearDone <= 1'b0;
               if (ClearReq) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  Busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == CNT_LAST) begin
                  state     <= DONE;
                  ClearDone <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               Busy      <= 1'b0;
               ClearDone <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               Busy      <= 1'b0;
               ClearDone <= 1'b0;
            end
         endcase
      end
   end

   // Register array: normal writes when idle, one zeroed entry per edge while clearing.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            regs[RD] <= WriteData;
         end
         if (clr_en) begin
            regs[cnt[ADDR_WIDTH-1:0]] <= '0;
         end
      end
   end

   // Multiply result register, wiped on the final clear edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mulreg <= '0;
      end else if (clr_last) begin
         mulreg <= '0;
      end else if (mul_en) begin
         mulreg <= MulData;
      end
   end

   assign MulHi = mulreg[2*DATA_WIDTH-1:DATA_WIDTH];
   assign MulLo = mulreg[DATA_WIDTH-1:0];

   // Read-port mux: hardwired zero first, then same-cycle bypass, then stored value.
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] val;
      val = regs[addr];
      if (ZERO_REG && (addr == '0)) begin
         val = '0;
      end else if (BYPASS && RegWrite && !Busy && (RD == addr) &&
                   !(ZERO_REG && (RD == '0))) begin
         val = WriteData;
      end
      return val;
   endfunction

   // Port A read.
   always_comb begin
      ReadRS = read_port(RS);
   end

   // Port B read.
   always_comb begin
      ReadRT = read_port(RT);
   end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

   logic        Clock;
   logic        Reset;
   logic [3:0]  RS, RT, RD;
   logic [23:0] WriteData;
   logic        RegWrite;
   logic [23:0] ReadRS, ReadRT;
   logic        MulWrite;
   logic [47:0] MulData;
   logic [23:0] MulHi, MulLo;
   logic        ClearReq;
   logic        Busy, ClearDone;

   logic [23:0] nb_ReadRS, nb_ReadRT, nb_MulHi, nb_MulLo;
   logic        nb_Busy, nb_ClearDone;

   int checks;
   int failures;

   regfile_param dut (
      .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD),
      .WriteData(WriteData), .RegWrite(RegWrite),
      .ReadRS(ReadRS), .ReadRT(ReadRT),
      .MulWrite(MulWrite), .MulData(MulData), .MulHi(MulHi), .MulLo(MulLo),
      .ClearReq(ClearReq), .Busy(Busy), .ClearDone(ClearDone)
   );

   regfile_param #(.BYPASS(1'b0)) dut_nb (
      .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD),
      .WriteData(WriteData), .RegWrite(RegWrite),
      .ReadRS(nb_ReadRS), .ReadRT(nb_ReadRT),
      .MulWrite(MulWrite), .MulData(MulData), .MulHi(nb_MulHi), .MulLo(nb_MulLo),
      .ClearReq(ClearReq), .Busy(nb_Busy), .ClearDone(nb_ClearDone)
   );

   initial Clock = 1'b0;
   always #10 Clock = ~Clock;

   task automatic wr(input logic [3:0] a, input logic [23:0] d);
      @(posedge Clock); #1;
      RD = a; WriteData = d; RegWrite = 1'b1;
   endtask

   task automatic test_reset;
      for (int i = 1; i < 16; i++) wr(4'(i), 24'h100000 + 24'(i));
      @(posedge Clock); #1;
      RegWrite = 1'b0; MulWrite = 1'b1; MulData = 48'h123456_789ABC;
      @(posedge Clock); #1;
      MulWrite = 1'b0;
      @(posedge Clock); #2;
      Reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         RS = 4'(i); RT = 4'(15 - i);
         #1;
         checks++;
         if (ReadRS !== 24'h0) begin
            failures++; $display("FAIL reset_read_rs r%0d got=%h exp=000000", i, ReadRS);
         end
      end
      checks++;
      if (ReadRT !== 24'h0) begin
         failures++; $display("FAIL reset_read_rt got=%h exp=000000", ReadRT);
      end
      checks++;
      if (MulHi !== 24'h0 || MulLo !== 24'h0) begin
         failures++; $display("FAIL reset_mul got=%h_%h exp=0", MulHi, MulLo);
      end
      checks++;
      if (Busy !== 1'b0 || ClearDone !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", Busy, ClearDone);
      end
      @(posedge Clock); #1;
      Reset = 1'b0;
   endtask

   task automatic test_bypass;
      @(posedge Clock); #1;
      RD = 4'd5; WriteData = 24'hABCDEF; RegWrite = 1'b1; RS = 4'd5; RT = 4'd5;
      @(negedge Clock);
      checks++;
      if (ReadRS !== 24'hABCDEF) begin
         failures++; $display("FAIL bypass_rs got=%h exp=abcdef", ReadRS);
      end
      checks++;
      if (ReadRT !== 24'hABCDEF) begin
         failures++; $display("FAIL bypass_rt got=%h exp=abcdef", ReadRT);
      end
      checks++;
      if (nb_ReadRS !== 24'h0) begin
         failures++; $display("FAIL nobypass_rs got=%h exp=000000", nb_ReadRS);
      end
      RT = 4'd6;
      #1;
      checks++;
      if (ReadRT !== 24'h0) begin
         failures++; $display("FAIL bypass_other_addr got=%h exp=000000", ReadRT);
      end
      @(posedge Clock); #1;
      RegWrite = 1'b0;
      @(negedge Clock);
      checks++;
      if (ReadRS !== 24'hABCDEF) begin
         failures++; $display("FAIL stored_rs got=%h exp=abcdef", ReadRS);
      end
      checks++;
      if (nb_ReadRS !== 24'hABCDEF) begin
         failures++; $display("FAIL nobypass_stored got=%h exp=abcdef", nb_ReadRS);
      end
   endtask

   task automatic test_zero_reg;
      @(posedge Clock); #1;
      RD = 4'd0; WriteData = 24'h123456; RegWrite = 1'b1; RS = 4'd0; RT = 4'd0;
      @(negedge Clock);
      checks++;
      if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
         failures++; $display("FAIL zero_write_cycle got=%h/%h exp=0/0", ReadRS, ReadRT);
      end
      @(posedge Clock); #1;
      RegWrite = 1'b0;
      @(negedge Clock);
      checks++;
      if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
         failures++; $display("FAIL zero_after got=%h/%h exp=0/0", ReadRS, ReadRT);
      end
   endtask

   task automatic test_mul;
      @(posedge Clock); #1;
      MulWrite = 1'b1; MulData = 48'h000001_FFFFFE;
      @(negedge Clock);
      checks++;
      if (MulHi !== 24'h0 || MulLo !== 24'h0) begin
         failures++; $display("FAIL mul_no_bypass got=%h_%h exp=0", MulHi, MulLo);
      end
      @(posedge Clock); #1;
      MulWrite = 1'b0;
      @(negedge Clock);
      checks++;
      if (MulHi !== 24'h000001) begin
         failures++; $display("FAIL mul_hi got=%h exp=000001", MulHi);
      end
      checks++;
      if (MulLo !== 24'hFFFFFE) begin
         failures++; $display("FAIL mul_lo got=%h exp=fffffe", MulLo);
      end
   endtask

   task automatic test_clear;
      int busy_n, done_n, done_k, last_busy;
      for (int i = 1; i < 16; i++) wr(4'(i), 24'(i));
      @(posedge Clock); #1;
      RegWrite = 1'b0; MulWrite = 1'b1; MulData = 48'hABCDEF_123456;
      @(posedge Clock); #1;
      MulWrite = 1'b0; ClearReq = 1'b1; RS = 4'd3; RT = 4'd10;
      busy_n = 0; done_n = 0; done_k = -1; last_busy = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge Clock); #1;
         ClearReq = 1'b0;
         if (k == 9) begin
            RD = 4'd7; WriteData = 24'h000777; RegWrite = 1'b1; RS = 4'd7;
         end else if (k == 10) begin
            RegWrite = 1'b0; RS = 4'd3;
         end
         @(negedge Clock);
         if (Busy) begin busy_n++; last_busy = k; end
         if (ClearDone) begin done_n++; done_k = k; end
         if (k == 3) begin
            checks++;
            if (ReadRS !== 24'h000003) begin
               failures++; $display("FAIL clear_r3_before got=%h exp=000003", ReadRS);
            end
         end
         if (k == 4) begin
            checks++;
            if (ReadRS !== 24'h0) begin
               failures++; $display("FAIL clear_r3_after got=%h exp=000000", ReadRS);
            end
            checks++;
            if (ReadRT !== 24'h00000A) begin
               failures++; $display("FAIL clear_r10_pending got=%h exp=00000a", ReadRT);
            end
         end
         if (k == 9) begin
            checks++;
            if (ReadRS !== 24'h0) begin
               failures++; $display("FAIL clear_no_bypass_busy got=%h exp=000000", ReadRS);
            end
         end
      end
      checks++;
      if (busy_n != 17 || last_busy != 16) begin
         failures++; $display("FAIL clear_busy_len got=%0d last=%0d exp=17 last=16", busy_n, last_busy);
      end
      checks++;
      if (done_n != 1 || done_k != 16) begin
         failures++; $display("FAIL clear_done_pulse got=%0d at=%0d exp=1 at=16", done_n, done_k);
      end
      for (int i = 0; i < 16; i++) begin
         RS = 4'(i);
         #1;
         checks++;
         if (ReadRS !== 24'h0) begin
            failures++; $display("FAIL clear_final r%0d got=%h exp=000000", i, ReadRS);
         end
      end
      checks++;
      if (MulHi !== 24'h0 || MulLo !== 24'h0) begin
         failures++; $display("FAIL clear_mul got=%h_%h exp=0", MulHi, MulLo);
      end
   endtask

   task automatic test_reset_mid_clear;
      int busy_n, done_n;
      wr(4'd12, 24'h00000C);
      wr(4'd15, 24'h00000F);
      @(posedge Clock); #1;
      RegWrite = 1'b0; MulWrite = 1'b1; MulData = 48'h000001_000002;
      @(posedge Clock); #1;
      MulWrite = 1'b0; ClearReq = 1'b1; RS = 4'd12; RT = 4'd15;
      for (int k = 0; k <= 8; k++) begin
         @(posedge Clock); #1;
         ClearReq = 1'b0;
      end
      checks++;
      if (Busy !== 1'b1 || ReadRS !== 24'h00000C) begin
         failures++; $display("FAIL midclear_pre got=%b/%h exp=1/00000c", Busy, ReadRS);
      end
      #3;
      Reset = 1'b1;
      #1;
      checks++;
      if (Busy !== 1'b0 || ClearDone !== 1'b0) begin
         failures++; $display("FAIL midclear_busy got=%b/%b exp=0/0", Busy, ClearDone);
      end
      checks++;
      if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
         failures++; $display("FAIL midclear_regs got=%h/%h exp=0/0", ReadRS, ReadRT);
      end
      checks++;
      if (MulHi !== 24'h0 || MulLo !== 24'h0) begin
         failures++; $display("FAIL midclear_mul got=%h_%h exp=0", MulHi, MulLo);
      end
      @(posedge Clock); #1;
      Reset = 1'b0;
      done_n = 0; busy_n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clock);
         if (ClearDone) done_n++;
         if (Busy) busy_n++;
      end
      checks++;
      if (done_n != 0 || busy_n != 0) begin
         failures++; $display("FAIL midclear_aborted done=%0d busy=%0d exp=0/0", done_n, busy_n);
      end
      @(posedge Clock); #1;
      ClearReq = 1'b1;
      done_n = 0; busy_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge Clock); #1;
         ClearReq = 1'b0;
         @(negedge Clock);
         if (Busy) busy_n++;
         if (ClearDone) done_n++;
      end
      checks++;
      if (busy_n != 17 || done_n != 1) begin
         failures++; $display("FAIL reclear busy=%0d done=%0d exp=17/1", busy_n, done_n);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      Reset = 1'b1;
      RS = '0; RT = '0; RD = '0; WriteData = '0; RegWrite = 1'b0;
      MulWrite = 1'b0; MulData = '0; ClearReq = 1'b0;
      #25;
      Reset = 1'b0;
      test_reset();
      test_bypass();
      test_zero_reg();
      test_mul();
      test_clear();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
